// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and receiver state encoding.
package uart_pkg;

  // Defaults shared with the transmitter so both ends agree on the frame.
  localparam int UART_OS   = 16;
  localparam int UART_DBIT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: tick/line/read-strobe in, held byte and status out.
interface uart_rx_if;

  logic       s_tick;
  logic       rx;
  logic       rd_en;
  logic [7:0] dout;
  logic       rx_valid;
  logic       rx_done_tick;
  logic       frame_err;
  logic       overrun;

  modport master (
    output s_tick, rx, rd_en,
    input  dout, rx_valid, rx_done_tick, frame_err, overrun
  );

  modport slave (
    input  s_tick, rx, rd_en,
    output dout, rx_valid, rx_done_tick, frame_err, overrun
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single idle-high asynchronous input.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Reset to 1 so an idle-high line is not mistaken for a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start/data/stop recovery into a one-entry
// output register with valid/read handshake, framing-error and overrun flags.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for the synchronized line to go low
//   START | counting to mid start bit; high there means a glitch
//   DATA  | sampling DBIT data bits at mid-bit, LSB first
//   STOP  | waiting for mid stop bit, then completing the frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT = UART_DBIT,
  parameter int OS   = UART_OS
) (
  input logic      clock,
  input logic      reset,
  uart_rx_if.slave bus
);

  localparam int SW = $clog2(OS);
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_ONE  = NW'(1);

  logic            w_rx_s;

  rx_state_t       r_state;
  rx_state_t       w_state_nxt;
  logic [SW-1:0]   r_s;
  logic [SW-1:0]   w_s_nxt;
  logic [NW-1:0]   r_n;
  logic [NW-1:0]   w_n_nxt;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] w_b_nxt;
  logic            w_done;
  logic [7:0]      w_byte;

  logic [7:0]      r_dout;
  logic            r_valid;
  logic            r_ferr;
  logic            r_ovr;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (bus.rx),
    .o_q   (w_rx_s)
  );

  // FSM state, tick counter, bit counter and shift register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
    end
  end

  // Next-state and frame-completion decode; all counting gated by s_tick.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        // Leaving idle does not wait for a tick; the start-bit count
        // begins from the first low sample.
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_s_nxt     = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (r_s == S_MID) begin
            w_s_nxt = '0;
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_s_nxt = r_s + S_ONE;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (r_s == S_LAST) begin
            w_s_nxt = '0;
            w_b_nxt = {w_rx_s, r_b[DBIT-1:1]};
            if (r_n == N_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_n_nxt = r_n + N_ONE;
            end
          end else begin
            w_s_nxt = r_s + S_ONE;
          end
        end
      end
      STOP: begin
        // Completing at mid-stop leaves half a bit of slack so a
        // back-to-back start edge is never missed.
        if (bus.s_tick) begin
          if (r_s == S_LAST) begin
            w_done      = 1'b1;
            w_s_nxt     = '0;
            w_state_nxt = IDLE;
          end else begin
            w_s_nxt = r_s + S_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Zero-extend the received word to the byte-wide output.
  always_comb begin
    w_byte           = '0;
    w_byte[DBIT-1:0] = r_b;
  end

  // Output register and handshake: a completed frame always loads, even with
  // a framing error; overrun only when it replaces a byte nobody read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_done) begin
      r_dout  <= w_byte;
      r_ferr  <= ~w_rx_s;
      r_valid <= 1'b1;
      if (r_valid && !bus.rd_en) begin
        r_ovr <= 1'b1;
      end
    end else if (bus.rd_en && r_valid) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign bus.dout         = r_dout;
  assign bus.rx_valid     = r_valid;
  assign bus.rx_done_tick = w_done;
  assign bus.frame_err    = r_ferr;
  assign bus.overrun      = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a frame-level reference model.
module tb_uart_rx;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic s_tick = 1'b1;
  logic rx0 = 1'b1;
  logic rx7 = 1'b1;
  logic rd_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done7 = 0;
  int last_done_cyc = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       stop;
  } exp_t;
  exp_t pend[$];

  logic [7:0] m_dout = '0;
  logic       m_valid = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  uart_rx_if u_if0 ();
  uart_rx_if u_if7 ();

  assign u_if0.s_tick = s_tick;
  assign u_if0.rx     = rx0;
  assign u_if0.rd_en  = rd_en;
  assign u_if7.s_tick = s_tick;
  assign u_if7.rx     = rx7;
  assign u_if7.rd_en  = 1'b0;

  uart_rx #(.DBIT(8), .OS(16)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if0)
  );

  uart_rx #(.DBIT(7), .OS(16)) u_dut7 (
    .clock (clock),
    .reset (reset),
    .bus   (u_if7)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a frame started at cycle c completes (DBIT+1)*OS + OS/2 ticks
  // later plus 2 synchronizer clocks; outputs follow the handshake rules.
  always @(negedge clock) begin : cmp
    exp_t e;
    logic exp_done;
    if (!reset) begin
      m_dout  = '0;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      pend.delete();
    end
    while (pend.size() > 0 && pend[0].cyc < cyc) void'(pend.pop_front());
    exp_done = (pend.size() > 0) && (pend[0].cyc == cyc);
    chk("done_tick", 32'(u_if0.rx_done_tick), 32'(exp_done));
    chk("dout", 32'(u_if0.dout), 32'(m_dout));
    chk("rx_valid", 32'(u_if0.rx_valid), 32'(m_valid));
    chk("frame_err", 32'(u_if0.frame_err), 32'(m_ferr));
    chk("overrun", 32'(u_if0.overrun), 32'(m_ovr));
    if (u_if0.rx_done_tick) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (u_if7.rx_done_tick) done7++;
    if (reset && exp_done) begin
      e       = pend.pop_front();
      m_ovr   = m_ovr | (m_valid & ~rd_en);
      m_dout  = e.data;
      m_ferr  = ~e.stop;
      m_valid = 1'b1;
    end else if (reset && rd_en && m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input bit tgt7, input int nbits, input logic [7:0] data, input logic stop);
    exp_t e;
    logic b;
    if (!tgt7) begin
      e.cyc  = cyc + (nbits + 1) * 16 + 8 + 2;
      e.data = data;
      e.stop = stop;
      pend.push_back(e);
    end
    for (int i = 0; i < nbits + 2; i++) begin
      if (i == 0) b = 1'b0;
      else if (i == nbits + 1) b = stop;
      else b = data[i-1];
      if (tgt7) rx7 = b;
      else rx0 = b;
      idle(16);
    end
    if (tgt7) rx7 = 1'b1;
    else rx0 = 1'b1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int c0;
    int dc;
    idle(3);
    chk("rst_valid", 32'(u_if0.rx_valid), 32'd0);
    chk("rst_dout", 32'(u_if0.dout), 32'd0);
    reset = 1'b1;
    idle(5);

    // Clean 0xA5 frame, then read it.
    c0 = cyc;
    send(1'b0, 8, 8'hA5, 1'b1);
    chk("a5_latency", 32'(last_done_cyc - c0), 32'd154);
    chk("a5_dout", 32'(u_if0.dout), 32'hA5);
    chk("a5_valid", 32'(u_if0.rx_valid), 32'd1);
    chk("a5_ferr", 32'(u_if0.frame_err), 32'd0);
    chk("a5_ovr", 32'(u_if0.overrun), 32'd0);
    chk("a5_count", 32'(done_cnt), 32'd1);
    pop();
    chk("a5_read_valid", 32'(u_if0.rx_valid), 32'd0);
    chk("a5_read_dout", 32'(u_if0.dout), 32'hA5);

    // Short low glitch: no frame.
    rx0 = 1'b0;
    idle(4);
    rx0 = 1'b1;
    idle(200);
    chk("glitch_count", 32'(done_cnt), 32'd1);
    chk("glitch_valid", 32'(u_if0.rx_valid), 32'd0);

    // Framing error, then a good frame clears it.
    send(1'b0, 8, 8'h3C, 1'b0);
    idle(20);
    chk("fe_dout", 32'(u_if0.dout), 32'h3C);
    chk("fe_ferr", 32'(u_if0.frame_err), 32'd1);
    chk("fe_valid", 32'(u_if0.rx_valid), 32'd1);
    pop();
    send(1'b0, 8, 8'h81, 1'b1);
    chk("good_dout", 32'(u_if0.dout), 32'h81);
    chk("good_ferr", 32'(u_if0.frame_err), 32'd0);
    pop();

    // Back-to-back without reading: overrun.
    send(1'b0, 8, 8'h11, 1'b1);
    send(1'b0, 8, 8'h22, 1'b1);
    chk("ovr_dout", 32'(u_if0.dout), 32'h22);
    chk("ovr_flag", 32'(u_if0.overrun), 32'd1);
    chk("ovr_valid", 32'(u_if0.rx_valid), 32'd1);
    pop();
    chk("ovr_clr_flag", 32'(u_if0.overrun), 32'd0);
    chk("ovr_clr_valid", 32'(u_if0.rx_valid), 32'd0);

    // Read strobe in the exact cycle of the second frame's completion.
    c0 = cyc;
    fork
      begin
        send(1'b0, 8, 8'h44, 1'b1);
        send(1'b0, 8, 8'h99, 1'b1);
      end
      begin
        idle(314);
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
      end
    join
    chk("same_cyc_dout", 32'(u_if0.dout), 32'h99);
    chk("same_cyc_valid", 32'(u_if0.rx_valid), 32'd1);
    chk("same_cyc_ovr", 32'(u_if0.overrun), 32'd0);
    chk("same_cyc_done_at", 32'(last_done_cyc - c0), 32'd314);
    pop();

    // Reset in the middle of an 0xFF frame, then 0x5A.
    dc = done_cnt;
    rx0 = 1'b0;
    idle(16);
    rx0 = 1'b1;
    idle(40);
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(20);
    chk("abort_count", 32'(done_cnt), 32'(dc));
    chk("abort_valid", 32'(u_if0.rx_valid), 32'd0);
    send(1'b0, 8, 8'h5A, 1'b1);
    chk("after_rst_dout", 32'(u_if0.dout), 32'h5A);
    chk("after_rst_count", 32'(done_cnt), 32'(dc + 1));

    // Seven-bit instance.
    send(1'b1, 7, 8'h55, 1'b1);
    idle(4);
    chk("d7_count", 32'(done7), 32'd1);
    chk("d7_dout", 32'(u_if7.dout), 32'h55);
    chk("d7_bit7", 32'(u_if7.dout[7]), 32'd0);
    chk("d7_valid", 32'(u_if7.rx_valid), 32'd1);
    chk("d7_ferr", 32'(u_if7.frame_err), 32'd0);

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
